// File: rtl/sync_ram_ctrl_if.sv
// Request/response bundle for sync_ram_ctrl: valid/ready request side,
// read-data return, soft clear and clear-busy status.
interface sync_ram_ctrl_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
);
  logic              clr;
  logic              req_valid;
  logic              req_ready;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] din;
  logic [DATA_W-1:0] dout;
  logic              rd_valid;
  logic              init_busy;

  modport master (
    output clr, req_valid, we, addr, din,
    input  req_ready, dout, rd_valid, init_busy
  );

  modport slave (
    input  clr, req_valid, we, addr, din,
    output req_ready, dout, rd_valid, init_busy
  );
endinterface

// File: rtl/sync_ram_ctrl.sv
// Single-port synchronous RAM with clear sequencer and valid/ready requests.
// Define OUTREG_EN to add an output pipeline register (2-cycle read latency).
module sync_ram_ctrl #(
  parameter int                DATA_W    = 8,
  parameter int                ADDR_W    = 4,
  parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
  input logic           clk,
  input logic           rst_n,
  sync_ram_ctrl_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_W;
`ifdef OUTREG_EN
  localparam int STAGES = 1;
`else
  localparam int STAGES = 0;
`endif

  typedef enum logic {INIT, IDLE} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W:0]   clr_cnt, clr_cnt_nxt;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] dout_q;
  logic [STAGES:0]   vld_pipe;
  logic              acc, acc_rd;

  assign bus.req_ready = (state == IDLE);
  assign bus.init_busy = (state == INIT);
  assign acc           = bus.req_valid && bus.req_ready;
  assign acc_rd        = acc && !bus.we;
  assign bus.dout      = dout_q;
  assign bus.rd_valid  = vld_pipe[STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= INIT;
      clr_cnt <= '0;
    end else begin
      state   <= state_nxt;
      clr_cnt <= clr_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    clr_cnt_nxt = clr_cnt;
    unique case (state)
      INIT: begin
        clr_cnt_nxt = clr_cnt + 1'b1;
        if (clr_cnt == (ADDR_W+1)'(DEPTH-1)) state_nxt = IDLE;
      end
      IDLE: begin
        // a request on the clr edge still completes; the clear starts after it
        if (bus.clr) begin
          state_nxt   = INIT;
          clr_cnt_nxt = '0;
        end
      end
      default: state_nxt = INIT;
    endcase
  end

  // storage has no reset; its contents come only from the sequencer
  always_ff @(posedge clk) begin
    if (state == INIT)
      mem[clr_cnt[ADDR_W-1:0]] <= CLEAR_VAL;
    else if (acc && bus.we)
      mem[bus.addr] <= bus.din;
  end

`ifdef OUTREG_EN
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      rdata_q  <= '0;
      dout_q   <= '0;
    end else begin
      vld_pipe <= {vld_pipe[0], acc_rd};
      if (acc_rd)      rdata_q <= mem[bus.addr];
      if (vld_pipe[0]) dout_q  <= rdata_q;
    end
  end
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      dout_q   <= '0;
    end else begin
      vld_pipe[0] <= acc_rd;
      if (acc_rd) dout_q <= mem[bus.addr];
    end
  end
`endif
endmodule
